// File: rtl/secuenciador_inciso2_pkg.sv
// Shared constants for the truth-table sequencer: FSM states, default width,
// and the bit positions of X..M inside the input vector.
package secuenciador_inciso2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } estado_t;

  localparam int N_VARS_DEF = 5;

  localparam int POS_X = 4;
  localparam int POS_Y = 3;
  localparam int POS_Z = 2;
  localparam int POS_K = 1;
  localparam int POS_M = 0;

endpackage

// File: rtl/secuenciador_inciso2_if.sv
// Control/result bundle between the sequencer and its bench or board.
// The sequencer owns vars; the external function only returns f_in.
interface secuenciador_inciso2_if #(
  parameter int N_VARS = 5
);
  localparam int TW = 1 << N_VARS;

  logic              start;
  logic              abortar;
  logic              f_in;
  logic [TW-1:0]     esperado;
  logic [N_VARS-1:0] vars;
  logic              busy;
  logic              done;
  logic [TW-1:0]     tabla;
  logic [N_VARS:0]   unos;
  logic              error;
  logic [N_VARS-1:0] fallo_idx;

  modport master (
    output start, abortar, f_in, esperado,
    input  vars, busy, done, tabla, unos, error, fallo_idx
  );

  modport slave (
    input  start, abortar, f_in, esperado,
    output vars, busy, done, tabla, unos, error, fallo_idx
  );
endinterface

// File: rtl/secuenciador_inciso2_contador.sv
// Sweep counters: vector index plus per-vector settle counter.
// muestra marks the sample edge, ultimo flags the final vector.
module contador_barrido #(
  parameter int N_VARS = 5,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [N_VARS-1:0] idx_o,
  output logic              muestra_o,
  output logic              ultimo_o
);
  localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WW-1:0]     W_LAST  = WW'(SETTLE - 1);
  localparam logic [WW-1:0]     W_ONE   = WW'(1);
  localparam logic [N_VARS-1:0] IDX_ONE = N_VARS'(1);

  logic [N_VARS-1:0] idx_q, idx_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;

  assign muestra_o = en_i && (wcnt_q == W_LAST);
  assign ultimo_o  = (idx_q == '1);
  assign idx_o     = idx_q;

  // idx saturates at its maximum; the FSM leaves HOLD on that sample edge
  always_comb begin
    idx_d  = idx_q;
    wcnt_d = wcnt_q;
    if (clr_i) begin
      idx_d  = '0;
      wcnt_d = '0;
    end else if (en_i) begin
      if (muestra_o) begin
        wcnt_d = '0;
        if (!ultimo_o) idx_d = idx_q + IDX_ONE;
      end else begin
        wcnt_d = wcnt_q + W_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      wcnt_q <= '0;
    end else begin
      idx_q  <= idx_d;
      wcnt_q <= wcnt_d;
    end
  end
endmodule

// File: rtl/secuenciador_inciso2.sv
// Truth-table sequencer for F_Final(X,Y,Z,K,M): sweeps all input vectors,
// captures F into tabla, counts ones and flags the first expected-table miss.
module secuenciador_inciso2
  import secuenciador_inciso2_pkg::*;
#(
  parameter int N_VARS = N_VARS_DEF,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  secuenciador_inciso2_if.slave   bus
);
  localparam int TW = 1 << N_VARS;

  estado_t           state_q, state_d;
  logic [TW-1:0]     tabla_q, tabla_d;
  logic [N_VARS:0]   unos_q, unos_d;
  logic              error_q, error_d;
  logic [N_VARS-1:0] fallo_q, fallo_d;

  logic              clr;
  logic              en;
  logic [N_VARS-1:0] idx;
  logic              muestra;
  logic              ultimo;

  contador_barrido #(
    .N_VARS (N_VARS),
    .SETTLE (SETTLE)
  ) u_contador (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (clr),
    .en_i      (en),
    .idx_o     (idx),
    .muestra_o (muestra),
    .ultimo_o  (ultimo)
  );

  assign en            = (state_q == ST_HOLD);
  assign bus.busy      = (state_q == ST_HOLD);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.vars      = (state_q == ST_HOLD) ? idx : '0;
  assign bus.tabla     = tabla_q;
  assign bus.unos      = unos_q;
  assign bus.error     = error_q;
  assign bus.fallo_idx = fallo_q;

  always_comb begin
    state_d = state_q;
    tabla_d = tabla_q;
    unos_d  = unos_q;
    error_d = error_q;
    fallo_d = fallo_q;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abortar) begin
          clr     = 1'b1;
          tabla_d = '0;
          unos_d  = '0;
          error_d = 1'b0;
          fallo_d = '1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // an abort on a sample edge drops that sample; earlier ones stay visible
        if (bus.abortar) begin
          state_d = ST_IDLE;
        end else if (muestra) begin
          tabla_d[idx] = bus.f_in;
          unos_d       = unos_q + {{N_VARS{1'b0}}, bus.f_in};
          if ((bus.f_in != bus.esperado[idx]) && !error_q) begin
            error_d = 1'b1;
            fallo_d = idx;
          end
          if (ultimo) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tabla_q <= '0;
      unos_q  <= '0;
      error_q <= 1'b0;
      fallo_q <= '1;
    end else begin
      state_q <= state_d;
      tabla_q <= tabla_d;
      unos_q  <= unos_d;
      error_q <= error_d;
      fallo_q <= fallo_d;
    end
  end
endmodule

// File: tb/tb_secuenciador_inciso2.sv
// Directed bench for the truth-table sequencer: SETTLE=1 and SETTLE=3 instances,
// with F modelled as a constant or as the M input.
module tb_secuenciador_inciso2;
  import secuenciador_inciso2_pkg::*;

  logic clk;
  logic reset;
  int   nvec;
  int   nmis;
  int   fmode_a;
  int   fmode_b;

  secuenciador_inciso2_if #(.N_VARS(5)) bus_a ();
  secuenciador_inciso2_if #(.N_VARS(5)) bus_b ();

  secuenciador_inciso2 #(.N_VARS(5), .SETTLE(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  secuenciador_inciso2 #(.N_VARS(5), .SETTLE(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: F=0, 1: F=M, 2: F=1
  always_comb begin
    bus_a.f_in = 1'b0;
    if (fmode_a == 1) bus_a.f_in = bus_a.vars[POS_M];
    else if (fmode_a == 2) bus_a.f_in = 1'b1;
    bus_b.f_in = 1'b0;
    if (fmode_b == 1) bus_b.f_in = bus_b.vars[POS_M];
    else if (fmode_b == 2) bus_b.f_in = 1'b1;
  end

  // Start at edge 0, then run 60 edges; optional abort / extra start at a given edge.
  task automatic do_sweep(input int abort_at, input int start_again,
                          output int done_edge, output int done_cnt, output bit vars_ok);
    int limit;
    limit = (abort_at >= 0 && abort_at < 32) ? abort_at : 32;
    @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    done_edge = -1;
    done_cnt  = 0;
    vars_ok   = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      bus_a.abortar = (n == abort_at);
      bus_a.start   = (n == start_again);
      @(negedge clk);
      if (bus_a.done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = n;
      end
      if (n < limit) begin
        if (!(bus_a.busy === 1'b1 && bus_a.vars === 5'(n))) vars_ok = 1'b0;
      end else begin
        if (!(bus_a.busy === 1'b0 && bus_a.vars === 5'd0)) vars_ok = 1'b0;
      end
    end
    bus_a.abortar = 1'b0;
    bus_a.start   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    nvec++; if (bus_a.vars !== 5'd0) begin nmis++; $display("FAIL reset_vars got %h want 00", bus_a.vars); end
    nvec++; if (bus_a.busy !== 1'b0) begin nmis++; $display("FAIL reset_busy got %b want 0", bus_a.busy); end
    nvec++; if (bus_a.done !== 1'b0) begin nmis++; $display("FAIL reset_done got %b want 0", bus_a.done); end
    nvec++; if (bus_a.tabla !== 32'h0) begin nmis++; $display("FAIL reset_tabla got %h want 0", bus_a.tabla); end
    nvec++; if (bus_a.unos !== 6'd0) begin nmis++; $display("FAIL reset_unos got %0d want 0", bus_a.unos); end
    nvec++; if (bus_a.error !== 1'b0) begin nmis++; $display("FAIL reset_error got %b want 0", bus_a.error); end
    nvec++; if (bus_a.fallo_idx !== 5'h1F) begin nmis++; $display("FAIL reset_fallo got %h want 1f", bus_a.fallo_idx); end
  endtask

  task automatic test_zeros();
    int de, dc; bit vok;
    fmode_a = 0; bus_a.esperado = 32'h0;
    do_sweep(-1, -1, de, dc, vok);
    nvec++; if (de !== 32) begin nmis++; $display("FAIL zeros_done_edge got %0d want 32", de); end
    nvec++; if (dc !== 1) begin nmis++; $display("FAIL zeros_done_cnt got %0d want 1", dc); end
    nvec++; if (vok !== 1'b1) begin nmis++; $display("FAIL zeros_vars_seq got %b want 1", vok); end
    nvec++; if (bus_a.tabla !== 32'h0) begin nmis++; $display("FAIL zeros_tabla got %h want 0", bus_a.tabla); end
    nvec++; if (bus_a.unos !== 6'd0) begin nmis++; $display("FAIL zeros_unos got %0d want 0", bus_a.unos); end
    nvec++; if (bus_a.error !== 1'b0) begin nmis++; $display("FAIL zeros_error got %b want 0", bus_a.error); end
    nvec++; if (bus_a.fallo_idx !== 5'h1F) begin nmis++; $display("FAIL zeros_fallo got %h want 1f", bus_a.fallo_idx); end
  endtask

  task automatic test_parity();
    int de, dc; bit vok;
    fmode_a = 1; bus_a.esperado = 32'hAAAAAAAA;
    do_sweep(-1, -1, de, dc, vok);
    nvec++; if (bus_a.tabla !== 32'hAAAAAAAA) begin nmis++; $display("FAIL parity_tabla got %h want aaaaaaaa", bus_a.tabla); end
    nvec++; if (bus_a.unos !== 6'd16) begin nmis++; $display("FAIL parity_unos got %0d want 16", bus_a.unos); end
    nvec++; if (bus_a.error !== 1'b0) begin nmis++; $display("FAIL parity_error got %b want 0", bus_a.error); end
    nvec++; if (bus_a.fallo_idx !== 5'h1F) begin nmis++; $display("FAIL parity_fallo got %h want 1f", bus_a.fallo_idx); end
  endtask

  task automatic test_first_miss();
    fmode_a = 1; bus_a.esperado = 32'hAAAAAAAB;
    @(negedge clk); bus_a.start = 1'b1;
    @(negedge clk); bus_a.start = 1'b0;
    @(negedge clk);
    nvec++; if (bus_a.error !== 1'b1) begin nmis++; $display("FAIL miss0_error_edge1 got %b want 1", bus_a.error); end
    nvec++; if (bus_a.fallo_idx !== 5'd0) begin nmis++; $display("FAIL miss0_fallo_edge1 got %h want 00", bus_a.fallo_idx); end
    repeat (40) @(negedge clk);
    nvec++; if (bus_a.error !== 1'b1) begin nmis++; $display("FAIL miss0_error_end got %b want 1", bus_a.error); end
    nvec++; if (bus_a.fallo_idx !== 5'd0) begin nmis++; $display("FAIL miss0_fallo_end got %h want 00", bus_a.fallo_idx); end
  endtask

  task automatic test_last_miss();
    int de, dc; bit vok;
    fmode_a = 1; bus_a.esperado = 32'h2AAAAAAA;
    do_sweep(-1, -1, de, dc, vok);
    nvec++; if (bus_a.error !== 1'b1) begin nmis++; $display("FAIL miss31_error got %b want 1", bus_a.error); end
    nvec++; if (bus_a.fallo_idx !== 5'd31) begin nmis++; $display("FAIL miss31_fallo got %h want 1f", bus_a.fallo_idx); end
    nvec++; if (dc !== 1) begin nmis++; $display("FAIL miss31_done_cnt got %0d want 1", dc); end
    nvec++; if (de !== 32) begin nmis++; $display("FAIL miss31_done_edge got %0d want 32", de); end
  endtask

  task automatic test_sticky();
    int de, dc; bit vok;
    fmode_a = 1; bus_a.esperado = 32'h0;
    do_sweep(-1, -1, de, dc, vok);
    nvec++; if (bus_a.fallo_idx !== 5'd1) begin nmis++; $display("FAIL sticky_fallo got %h want 01", bus_a.fallo_idx); end
    nvec++; if (bus_a.error !== 1'b1) begin nmis++; $display("FAIL sticky_error got %b want 1", bus_a.error); end
  endtask

  task automatic test_settle3();
    int de; bit vok;
    fmode_b = 2; bus_b.esperado = 32'hFFFFFFFF;
    de = -1; vok = 1'b1;
    @(negedge clk); bus_b.start = 1'b1;
    @(negedge clk); bus_b.start = 1'b0;
    for (int n = 1; n <= 110; n++) begin
      @(negedge clk);
      if (bus_b.done && de < 0) de = n;
      if (n < 96 && bus_b.vars !== 5'(n / 3)) vok = 1'b0;
    end
    nvec++; if (vok !== 1'b1) begin nmis++; $display("FAIL settle3_vars_hold got %b want 1", vok); end
    nvec++; if (de !== 96) begin nmis++; $display("FAIL settle3_done_edge got %0d want 96", de); end
    nvec++; if (bus_b.unos !== 6'd32) begin nmis++; $display("FAIL settle3_unos got %0d want 32", bus_b.unos); end
    nvec++; if (bus_b.tabla !== 32'hFFFFFFFF) begin nmis++; $display("FAIL settle3_tabla got %h want ffffffff", bus_b.tabla); end
  endtask

  task automatic test_abort();
    int de, dc; bit vok;
    fmode_a = 1; bus_a.esperado = 32'hAAAAAAAA;
    do_sweep(10, -1, de, dc, vok);
    nvec++; if (vok !== 1'b1) begin nmis++; $display("FAIL abort_busy_vars got %b want 1", vok); end
    nvec++; if (dc !== 0) begin nmis++; $display("FAIL abort_done_cnt got %0d want 0", dc); end
  endtask

  task automatic test_abort_in_done();
    int de, dc; bit vok;
    do_sweep(33, -1, de, dc, vok);
    nvec++; if (dc !== 1) begin nmis++; $display("FAIL abort_done_cnt2 got %0d want 1", dc); end
    nvec++; if (de !== 32) begin nmis++; $display("FAIL abort_done_edge2 got %0d want 32", de); end
  endtask

  task automatic test_abort_beats_start();
    @(negedge clk); bus_a.start = 1'b1; bus_a.abortar = 1'b1;
    @(negedge clk); bus_a.start = 1'b0; bus_a.abortar = 1'b0;
    @(negedge clk);
    nvec++; if (bus_a.busy !== 1'b0) begin nmis++; $display("FAIL abort_vs_start_busy got %b want 0", bus_a.busy); end
    nvec++; if (bus_a.tabla !== 32'hAAAAAAAA) begin nmis++; $display("FAIL abort_vs_start_tabla got %h want aaaaaaaa", bus_a.tabla); end
  endtask

  task automatic test_back_to_back();
    int de, dc; bit vok;
    fmode_a = 2; bus_a.esperado = 32'hFFFFFFFF;
    do_sweep(-1, 3, de, dc, vok);
    nvec++; if (de !== 32) begin nmis++; $display("FAIL restart_done_edge got %0d want 32", de); end
    nvec++; if (dc !== 1) begin nmis++; $display("FAIL restart_done_cnt got %0d want 1", dc); end
    nvec++; if (vok !== 1'b1) begin nmis++; $display("FAIL restart_vars_seq got %b want 1", vok); end
    nvec++; if (bus_a.unos !== 6'd32) begin nmis++; $display("FAIL restart_unos got %0d want 32", bus_a.unos); end
  endtask

  task automatic test_reset_mid();
    fmode_a = 1; bus_a.esperado = 32'h0;
    @(negedge clk); bus_a.start = 1'b1;
    @(negedge clk); bus_a.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nvec++; if (bus_a.busy !== 1'b0) begin nmis++; $display("FAIL rstmid_busy got %b want 0", bus_a.busy); end
    nvec++; if (bus_a.vars !== 5'd0) begin nmis++; $display("FAIL rstmid_vars got %h want 00", bus_a.vars); end
    nvec++; if (bus_a.tabla !== 32'h0) begin nmis++; $display("FAIL rstmid_tabla got %h want 0", bus_a.tabla); end
    nvec++; if (bus_a.unos !== 6'd0) begin nmis++; $display("FAIL rstmid_unos got %0d want 0", bus_a.unos); end
    nvec++; if (bus_a.error !== 1'b0) begin nmis++; $display("FAIL rstmid_error got %b want 0", bus_a.error); end
    nvec++; if (bus_a.fallo_idx !== 5'h1F) begin nmis++; $display("FAIL rstmid_fallo got %h want 1f", bus_a.fallo_idx); end
    repeat (3) @(negedge clk);
    nvec++; if (bus_a.done !== 1'b0) begin nmis++; $display("FAIL rstmid_done got %b want 0", bus_a.done); end
  endtask

  initial begin
    nvec = 0; nmis = 0;
    fmode_a = 0; fmode_b = 0;
    reset = 1'b1;
    bus_a.start = 1'b0; bus_a.abortar = 1'b0; bus_a.esperado = '0;
    bus_b.start = 1'b0; bus_b.abortar = 1'b0; bus_b.esperado = '0;
    test_reset();
    test_zeros();
    test_parity();
    test_first_miss();
    test_last_miss();
    test_sticky();
    test_settle3();
    test_abort();
    test_abort_in_done();
    test_abort_beats_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
